// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO slave emulating an 88E1111-style PHY register map.
// MDC/MDIO are oversampled in the clk domain; reads answer from a snapshot taken at REGAD end.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'h01,
  parameter logic [15:0] PHY_ID1      = 16'h0141,
  parameter logic [15:0] PHY_ID2      = 16'h0CC2,
  parameter logic [15:0] CTRL_RST_VAL = 16'h1140
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        link_up,
  input  logic [1:0]  speed,
  output logic [15:0] ctrl_reg,
  output logic        soft_rst
);

  typedef enum logic {HUNT, FRAME} state_t;

  state_t      state;
  logic [1:0]  mdc_sync;
  logic        mdc_hist;
  logic [1:0]  mdio_sync;
  logic [5:0]  ones;
  logic [4:0]  bit_idx;
  logic        op_hi;
  logic        is_read;
  logic        hit;
  logic [4:0]  phyad;
  logic [4:0]  regad;
  logic [15:0] shreg;
  logic [15:0] ctrl_q;

  logic        rise;
  logic        fall;
  logic        mdio_bit;
  logic [4:0]  regad_next;
  logic [15:0] wr_word;

  function automatic logic [15:0] read_word(input logic [4:0] ra, input logic [15:0] ctrl,
                                            input logic lk, input logic [1:0] sp);
    logic [15:0] w;
    w = 16'h0000;
    case (ra)
      5'd0:  w = {1'b0, ctrl[14:0]};
      5'd1:  begin
               w    = 16'h7949;
               w[5] = lk;
               w[2] = lk;
             end
      5'd2:  w = PHY_ID1;
      5'd3:  w = PHY_ID2;
      5'd17: w = {sp, 1'b1, 1'b0, lk, lk, 10'b0};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  // Idle-high reset values so leaving reset never fakes an MDC rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mdc_sync  <= 2'b11;
      mdc_hist  <= 1'b1;
      mdio_sync <= 2'b11;
    end else begin
      mdc_sync  <= {mdc_sync[0], mdc};
      mdc_hist  <= mdc_sync[1];
      mdio_sync <= {mdio_sync[0], mdio_i};
    end
  end

  assign rise       = mdc_sync[1] & ~mdc_hist;
  assign fall       = ~mdc_sync[1] & mdc_hist;
  assign mdio_bit   = mdio_sync[1];
  assign regad_next = {regad[3:0], mdio_bit};
  assign wr_word    = {shreg[14:0], mdio_bit};
  assign ctrl_reg   = ctrl_q;

  // Frame decode runs on MDC rises; bus drive changes only on MDC falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= HUNT;
      ones     <= 6'd0;
      bit_idx  <= 5'd0;
      op_hi    <= 1'b0;
      is_read  <= 1'b0;
      hit      <= 1'b0;
      phyad    <= 5'd0;
      regad    <= 5'd0;
      shreg    <= 16'h0000;
      ctrl_q   <= CTRL_RST_VAL;
      soft_rst <= 1'b0;
      mdio_o   <= 1'b0;
      mdio_oe  <= 1'b0;
    end else begin
      soft_rst <= 1'b0;
      if (rise) begin
        case (state)
          HUNT: begin
            if (mdio_bit) begin
              if (ones != 6'd32) ones <= ones + 6'd1;
            end else if (ones == 6'd32) begin
              state   <= FRAME;
              bit_idx <= 5'd1;
              ones    <= 6'd0;
            end else begin
              ones <= 6'd0;
            end
          end
          FRAME: begin
            bit_idx <= bit_idx + 5'd1;
            if (bit_idx == 5'd1) begin
              if (!mdio_bit) begin
                state   <= HUNT;
                bit_idx <= 5'd0;
              end
            end else if (bit_idx == 5'd2) begin
              op_hi <= mdio_bit;
            end else if (bit_idx == 5'd3) begin
              is_read <= op_hi & ~mdio_bit;
              if (op_hi == mdio_bit) begin
                state   <= HUNT;
                bit_idx <= 5'd0;
              end
            end else if (bit_idx <= 5'd8) begin
              phyad <= {phyad[3:0], mdio_bit};
            end else if (bit_idx <= 5'd13) begin
              regad <= regad_next;
              if (bit_idx == 5'd13) begin
                hit   <= (phyad == PHY_ADDR);
                shreg <= read_word(regad_next, ctrl_q, link_up, speed);
              end
            end else if (bit_idx >= 5'd16) begin
              if (!is_read) shreg <= wr_word;
              if (bit_idx == 5'd31) begin
                state   <= HUNT;
                bit_idx <= 5'd0;
                if (hit && !is_read && regad == 5'd0) begin
                  if (wr_word[15]) begin
                    ctrl_q   <= CTRL_RST_VAL;
                    soft_rst <= 1'b1;
                  end else begin
                    ctrl_q <= {1'b0, wr_word[14:0]};
                  end
                end
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
      if (fall) begin
        if (state == HUNT) begin
          mdio_oe <= 1'b0;
          mdio_o  <= 1'b0;
        end else if (hit && is_read) begin
          if (bit_idx == 5'd15) begin
            mdio_oe <= 1'b1;
            mdio_o  <= 1'b0;
          end else if (bit_idx >= 5'd16) begin
            mdio_o <= shreg[15];
            shreg  <= {shreg[14:0], 1'b0};
          end
        end
      end
    end
  end

endmodule
